// File: rtl/rb_line_sequencer.sv
// rb_line_sequencer: streams a frame pixel-by-pixel into the rotating-buffer line store and flags full K-row column windows.
module rb_line_sequencer #(
  parameter int K           = 5,
  parameter int PIXEL_WIDTH = 8,
  parameter int IMG_W       = 64,
  parameter int IMG_H       = 64,
  parameter int EMEM_AW     = 12,
  parameter int BRAM_W_AW   = 14,
  parameter int BRAM_R_AW   = 12,
  parameter int RB_ADDR     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 complete,
  output logic [EMEM_AW-1:0]   e_mem_addr,
  output logic                 en_e_mem,
  output logic                 en_a,
  output logic [BRAM_W_AW-1:0] w_bram_addr,
  output logic                 en_b,
  output logic [BRAM_R_AW-1:0] r_bram_addr,
  output logic [RB_ADDR-1:0]   steer,
  output logic                 steer_en,
  output logic                 out_valid,
  input  logic                 out_ready
);
  localparam int CW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int RW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  if (PIXEL_WIDTH * (K - 1) > 32 || IMG_W < 2 || IMG_H < K) begin : g_param_check
    $error("rb_line_sequencer: K-1 rows must fit the 32-bit port B word and the frame must hold a window");
  end
  typedef enum logic [2:0] {IDLE, FILL, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [RB_ADDR-1:0] lane;
  logic issue, col_last, row_last, run_issue;
  always_comb begin
    issue = (state == FILL || state == RUN) && (!out_valid || out_ready);
    col_last = col == CW'(IMG_W - 1);
    row_last = row == RW'(IMG_H - 1);
    run_issue = issue && state == RUN;
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? FILL : IDLE;
      FILL:    state_nx = issue && col_last && row == RW'(K - 2) ? RUN : FILL;
      RUN:     state_nx = issue && col_last && row_last ? DRAIN : RUN;
      DRAIN:   state_nx = out_valid && out_ready ? DONE : DRAIN;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  assign busy        = state != IDLE;
  assign complete    = state == DONE;
  assign en_e_mem    = issue;
  assign en_a        = issue;
  assign en_b        = issue;
  assign steer_en    = out_valid;
  assign r_bram_addr = BRAM_R_AW'(col);
  assign w_bram_addr = BRAM_W_AW'(col) * BRAM_W_AW'(K - 1) + BRAM_W_AW'(lane);
  // Counters freeze on the final issue so addresses keep showing the last pixel after the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      lane       <= '0;
      e_mem_addr <= '0;
      out_valid  <= 1'b0;
      steer      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        row        <= '0;
        col        <= '0;
        lane       <= '0;
        e_mem_addr <= '0;
      end else if (issue && !(col_last && row_last)) begin
        col        <= col_last ? '0 : col + 1'b1;
        row        <= col_last ? row + 1'b1 : row;
        lane       <= col_last ? (lane == RB_ADDR'(K - 2) ? '0 : lane + 1'b1) : lane;
        e_mem_addr <= e_mem_addr + 1'b1;
      end
      out_valid <= run_issue || (out_valid && !out_ready);
      if (run_issue) steer <= lane;
    end
  end
endmodule
